// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO port: register offsets.
package gpio_pkg;

   localparam int GPIO_OFS_W = 3;

   typedef enum logic [GPIO_OFS_W-1:0] {
      REG_OUT = 3'd0,
      REG_DIR = 3'd1,
      REG_IN  = 3'd2,
      REG_SET = 3'd3,
      REG_CLR = 3'd4,
      REG_TGL = 3'd5,
      REG_IE  = 3'd6,
      REG_IS  = 3'd7
   } gpio_reg_e;

endpackage

// File: rtl/gpio_sync.sv
// Pad input synchroniser chain plus a one-cycle delayed copy used for
// rising-edge detection. All stages clear on reset, so a pin that is already
// high when reset is released shows up as one rising edge.
module gpio_sync
   import gpio_pkg::*;
#(
   parameter int WIDTH  = 6,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pad,
   output logic [WIDTH-1:0] in_sync,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] chain [STAGES];
   logic [WIDTH-1:0] prev;

   // Shift the pad value through the synchroniser and keep the previous output.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
         prev <= '0;
      end else begin
         chain[0] <= pad;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
         prev <= chain[STAGES-1];
      end
   end

   assign in_sync = chain[STAGES-1];
   assign rise    = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO peripheral on the CPU data port: output latch with
// atomic set/clear/toggle, direction control, synchronised inputs and
// rising-edge interrupt status (write-1-to-clear).
module gpio_port
   import gpio_pkg::*;
#(
   parameter int         WIDTH       = 6,
   parameter int         SYNC_STAGES = 2,
   parameter logic [3:0] BASE        = 4'h9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [3:0]       wen,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             hit_q,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   logic             hit;
   logic             wr;
   logic             rd;
   gpio_reg_e        ofs;
   logic [31:0]      lane_mask;
   logic [WIDTH-1:0] wmask;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] dir_q;
   logic [WIDTH-1:0] ie_q;
   logic [WIDTH-1:0] is_q;
   logic [WIDTH-1:0] is_next;
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] rise;
   logic [31:0]      rd_val;
   logic             unused_bits;

   assign hit  = en && (addr[31:28] == BASE);
   assign wr   = hit && (wen != 4'b0000);
   assign rd   = hit && (wen == 4'b0000);
   assign ofs  = gpio_reg_e'(addr[4:2]);

   assign lane_mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
   assign wmask     = lane_mask[WIDTH-1:0];
   assign wd        = wdata[WIDTH-1:0] & wmask;

   // Address bits outside the decode/select fields and wdata/lane bits above
   // WIDTH are intentionally ignored.
   assign unused_bits = ^{addr[27:5], addr[1:0], wdata, lane_mask};

   gpio_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .pad     (gpio_i),
      .in_sync (in_sync),
      .rise    (rise)
   );

   // Interrupt status: W1C first, then new edges on input pins so a
   // coincident edge keeps the bit set.
   always_comb begin
      is_next = is_q;
      if (wr && ofs == REG_IS) is_next = is_q & ~wd;
      is_next = is_next | (rise & ~dir_q);
   end

   // Read mux; write-only offsets and bits above WIDTH return zero.
   always_comb begin
      rd_val = '0;
      case (ofs)
         REG_OUT: rd_val = 32'(out_q);
         REG_DIR: rd_val = 32'(dir_q);
         REG_IN:  rd_val = 32'(in_sync);
         REG_IE:  rd_val = 32'(ie_q);
         REG_IS:  rd_val = 32'(is_q);
         default: rd_val = '0;
      endcase
   end

   // Register writes, interrupt status update and registered read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
         dir_q <= '0;
         ie_q  <= '0;
         is_q  <= '0;
         rdata <= '0;
         hit_q <= 1'b0;
      end else begin
         if (wr) begin
            case (ofs)
               REG_OUT: out_q <= (out_q & ~wmask) | wd;
               REG_DIR: dir_q <= (dir_q & ~wmask) | wd;
               REG_SET: out_q <= out_q | wd;
               REG_CLR: out_q <= out_q & ~wd;
               REG_TGL: out_q <= out_q ^ wd;
               REG_IE:  ie_q  <= (ie_q & ~wmask) | wd;
               default: ;
            endcase
         end
         is_q  <= is_next;
         rdata <= rd ? rd_val : '0;
         hit_q <= hit;
      end
   end

   assign gpio_o  = out_q;
   assign gpio_oe = dir_q;
   assign irq     = |(is_q & ie_q);

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised memory-mapped GPIO peripheral. It is the successor of the fixed 6-bit output latch decoded at address region 0x9 in the CPU top. It adds direction control, synchronised inputs, atomic set/clear/toggle, and rising-edge interrupts. It sits on the CPU data-memory port beside dtcm; the top muxes `rdata` using `hit_q`.

## Interface
- `WIDTH`, 6, number of GPIO pins, 1..32
- `SYNC_STAGES`, 2, input synchroniser depth, ≥2
- `BASE`, 4'h9, value of addr[31:28] that selects this block
- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `en` in 1: data-port access strobe
- `wen` in 4: byte write enables; 0 means read
- `addr` in 32: byte address; [31:28] decode, [4:2] register select
- `wdata` in 32: write data
- `rdata` out 32: registered read data
- `hit_q` out 1: previous-cycle access hit this block (top read-mux select)
- `gpio_i` in WIDTH: asynchronous pad inputs
- `gpio_o` out WIDTH: output values
- `gpio_oe` out WIDTH: output enables, 1 = drive
- `irq` out 1: level interrupt

## Operation
- hit = en && addr[31:28]==BASE. Writes require hit and wen≠0. Reads require hit and wen==0.
- Byte-lane masking applies to all writes: field bit i is affected only if wen[i/8]. Bits ≥WIDTH are ignored on write and read as 0.
- Register map by addr[4:2]:
  - 0 OUT, rw
  - 1 DIR, rw, 1 = output
  - 2 IN, ro, last synchroniser stage
  - 3 SET, wo: OUT |= wdata
  - 4 CLR, wo: OUT &= ~wdata
  - 5 TGL, wo: OUT ^= wdata
  - 6 IE, rw
  - 7 IS, rw1c
- Write-only registers read as 0.
- gpio_o = OUT and gpio_oe = DIR, driven directly from flops.
- The synchroniser is a SYNC_STAGES-deep flop chain per bit. `prev` holds IN delayed by one cycle.
- A rising edge (IN & ~prev & ~DIR) sets the matching IS bit.
- Simultaneous edge and W1C on the same bit: the set wins and the bit stays 1.
- irq = |(IS & IE), combinational from flops.
- Reset values:
  - OUT, DIR, IE, IS, rdata, hit_q = 0
  - synchroniser and prev = 0, so a pin already high at reset release produces one edge
  - gpio_o = gpio_oe = 0; irq = 0
- A reset asserted mid-access aborts the write. rdata is 0 the next cycle.

## Timing
- Register writes take effect at the edge where the access is presented. gpio_o and gpio_oe change immediately after that edge.
- Read latency is 1 cycle:
  - rdata and hit_q are registered from the access cycle.
  - If the access was not a read hit, rdata = 0.
- Read and write to different registers in back-to-back cycles: each completes independently. A read of OUT in cycle n+1 returns the value written in cycle n.
- Input latency: a pad change sampled at edge k appears in IN at edge k+SYNC_STAGES−1. IS and irq are set at edge k+SYNC_STAGES.
- A W1C of IS at edge k clears irq after edge k, provided no new edge arrives in that same cycle.

## Structure
- Package `gpio_pkg`:
  - enum `gpio_reg_e` for the eight offsets
  - localparam `GPIO_OFS_W = 3`
- Sub-module `gpio_sync` (parameters WIDTH, STAGES): the synchroniser chain plus the `prev` register. Outputs are `in_sync` and `rise`.
- All other logic lives in gpio_port, roughly 150–200 lines in total.

## Test plan
- Reset then read all 8 offsets → rdata = 0 each time, one cycle after the access; hit_q = 1.
- Write OUT = 0x15 with wen=4'b0001, then SET 0x02, CLR 0x04, TGL 0x21 → gpio_o = 0x15, 0x17, 0x13, 0x32 on successive cycles; a read of OUT returns 0x32.
- Write OUT = 0x3F with wen=4'b0010 → OUT unchanged (bits in lane 1 are ≥WIDTH). Write to address 0x8000_0000 → no effect and hit_q = 0.
- DIR = 0, IE = 0x01, drive gpio_i[0] 0→1 at edge k → IN[0] = 1 at k+1 and IS = 0x01 with irq = 1 at k+2. W1C IS = 0x01 → irq = 0.
- Falling edge, or rising edge on a pin with DIR = 1 → IS stays 0. Edge arriving in the same cycle as the W1C of that bit → IS bit remains 1.
- Assert reset with OUT = 0x2A and IS = 0x3 → next cycle gpio_o = 0, irq = 0, rdata = 0.
